// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit buffer.
// Launch FSM encoding, data width and default buffer depth.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int DEFAULT_DEPTH = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    LAUNCH    = ST_LAUNCH,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-write and uart_top launch signals of the transmit buffer.
// The slave side is the buffer; the master side drives it.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int ADDR_W = $clog2(DEPTH);

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [ADDR_W:0]        count;
  logic                   overflow;
  logic                   tx_start;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_busy;

  modport slave (
    input  wr_en,
    input  wr_data,
    input  tx_busy,
    output full,
    output empty,
    output count,
    output overflow,
    output tx_start,
    output tx_data
  );

  modport master (
    output wr_en,
    output wr_data,
    output tx_busy,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  tx_start,
    input  tx_data
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags.
// Full is judged before a same-cycle pop, so a write into a full buffer is refused.
module sync_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int WIDTH  = UART_DATA_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = wr_en_i & ~full_q;
  assign rd_ok = rd_en_i & ~empty_q;

  // Next pointers, occupancy and flags; pointers wrap by width.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en_i & full_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  // Control state; a reset flushes the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Data storage without reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer feeding uart_top one byte per frame.
// A launch waits for tx_busy to rise and fall before the next pop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  tx_state_e              state_q;
  logic                   tx_start_q;
  logic [UART_DATA_W-1:0] tx_data_q;
  logic                   pop;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ADDR_W:0]        fifo_count;
  logic                   fifo_ovf;

  assign pop = (state_q == IDLE) & ~fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wr_en),
    .wr_data_i  (bus.wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (rd_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (fifo_ovf)
  );

  // Launch FSM: pop and pulse, then track one full busy window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= rd_data;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start_q <= 1'b0;
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state_q <= IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = fifo_ovf;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model plus a
// scoreboard monitor on tx_start, with a randomized uart_top responder.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state: buffered bytes, launched-but-unchecked bytes.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         armed = 1'b1;
  bit         seen_busy = 1'b0;
  bit         skip = 1'b0;
  logic [7:0] last_tx = 8'h00;
  bit         e_start = 1'b0;
  bit         e_ovf = 1'b0;
  bit         long_busy = 1'b0;
  int         launches = 0;

  logic       s_wr, s_busy, s_rst, full_b, ne_b;
  logic [7:0] s_data;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference model: one step per clock edge, outputs compared just after.
  initial begin
    forever begin
      @(posedge clk);
      s_wr   = bus.wr_en;
      s_data = bus.wr_data;
      s_busy = bus.tx_busy;
      s_rst  = rst;
      if (s_rst) begin
        mq.delete();
        exp_q.delete();
        armed     = 1'b1;
        seen_busy = 1'b0;
        skip      = 1'b0;
        last_tx   = 8'h00;
        e_start   = 1'b0;
        e_ovf     = 1'b0;
      end else begin
        full_b  = (mq.size() == DEPTH);
        ne_b    = (mq.size() > 0);
        e_start = 1'b0;
        if (armed && ne_b) begin
          last_tx = mq.pop_front();
          exp_q.push_back(last_tx);
          e_start   = 1'b1;
          armed     = 1'b0;
          seen_busy = 1'b0;
          skip      = 1'b1;
        end else if (!armed) begin
          if (skip) skip = 1'b0;
          else if (!seen_busy) begin
            if (s_busy) seen_busy = 1'b1;
          end else if (!s_busy) armed = 1'b1;
        end
        e_ovf = s_wr && full_b;
        if (s_wr && !full_b) mq.push_back(s_data);
      end
      #1;
      check("count", 32'(bus.count), 32'(mq.size()));
      check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      check("empty", 32'(bus.empty), 32'(mq.size() == 0));
      check("overflow", 32'(bus.overflow), 32'(e_ovf));
      check("tx_start", 32'(bus.tx_start), 32'(e_start));
      check("tx_data", 32'(bus.tx_data), 32'(last_tx));
    end
  end

  // Scoreboard monitor: each launch must carry the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        launches++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_launch: got %0h want none", bus.tx_data);
        end else begin
          check("sb_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // uart_top stand-in: busy rises after a launch, stays a few cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_start) begin
        automatic int d = $urandom_range(0, 2);
        automatic int h = long_busy ? 60 : $urandom_range(2, 8);
        for (int i = 0; i < d && !rst; i++) @(negedge clk);
        if (!rst) bus.tx_busy = 1'b1;
        for (int i = 0; i < h && !rst; i++) @(negedge clk);
        bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic wr(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && exp_q.size() == 0 && armed && !bus.tx_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      $display("FAIL %s: got timeout want drained", nm);
    end
  endtask

  initial begin
    int l0;
    bit got;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // Reset held 100 ns.
    #100;
    @(negedge clk);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_start", 32'(bus.tx_start), 32'd0);
    check("rst_data", 32'(bus.tx_data), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_launches", 32'(launches), 32'd0);

    // Single byte, exact launch latency, then a burst behind it.
    wr(8'h41);
    check("lat_n1_start", 32'(bus.tx_start), 32'd0);
    check("lat_n1_empty", 32'(bus.empty), 32'd0);
    @(negedge clk);
    check("lat_n2_start", 32'(bus.tx_start), 32'd1);
    check("lat_n2_data", 32'(bus.tx_data), 32'h41);
    wr(8'h55);
    wr(8'hFF);
    wr(8'h00);
    check("burst_peak", 32'(bus.count), 32'd3);
    drain("drain_burst");

    // Fill past capacity while one frame is on the line.
    long_busy = 1'b1;
    for (int i = 0; i <= 16; i++) wr(8'(i));
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_full", 32'(bus.full), 32'd1);
    wr(8'hEE);
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    @(negedge clk);
    check("ovf_clear", 32'(bus.overflow), 32'd0);
    long_busy = 1'b0;
    drain("drain_wrap");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_data = 8'($urandom);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    drain("drain_rand");

    // Reset while a frame is on the line and bytes are queued.
    for (int i = 0; i < 6; i++) wr(8'($urandom));
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_busy) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      $display("FAIL busy_wait: got timeout want busy");
    end
    rst = 1'b1;
    #1;
    check("mid_empty", 32'(bus.empty), 32'd1);
    check("mid_count", 32'(bus.count), 32'd0);
    check("mid_start", 32'(bus.tx_start), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    l0 = launches;
    repeat (30) @(negedge clk);
    check("post_rst_quiet", 32'(launches - l0), 32'd0);
    wr(8'hA5);
    wr(8'h5A);
    drain("drain_post");
    check("post_rst_launch", 32'(launches - l0), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
